// File: rtl/mesh_link.sv
// mesh_link: link buffer between neighbouring tiles, sender handshake into a DEPTH-entry FIFO.
// Latency: a word captured at edge N is visible on recv_* in the next cycle (poppable at N+1).
// Backpressure: a full FIFO refuses capture (send_done stays low); recv side pops on valid & ready.
module mesh_link #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [WIDTH-1:0]           send_data,
  input  logic                       send_ready,
  output logic                       send_done,
  output logic [WIDTH-1:0]           recv_data,
  output logic                       recv_valid,
  input  logic                       recv_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACK} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Capture only from IDLE; the ACK cycle masks the still-asserted send_ready so a word
  // is never taken twice. Both decisions use pre-edge occupancy (no bypass at full).
  assign push = (state == IDLE) && send_ready && !full;
  assign pop  = !empty && recv_ready;

  assign recv_valid = !empty;
  assign recv_data  = mem[rd_ptr];

  // Input handshake FSM; send_done is registered and mirrors the ACK state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      send_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            state     <= ACK;
            send_done <= 1'b1;
          end else begin
            send_done <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          send_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; contents are not reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= send_data;
    end
  end

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_link.sv
// tb_mesh_link: scoreboard bench for mesh_link at DEPTH=2 (d2) and DEPTH=3 (d3).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected words are queued when offered and compared when the bench pops them.
module tb_mesh_link;

  logic clk;
  logic nrst;

  logic [31:0] s2_data, s3_data;
  logic        s2_ready, s3_ready;
  logic        d2_done, d3_done;
  logic [31:0] d2_data, d3_data;
  logic        d2_valid, d3_valid;
  logic        r2_ready, r3_ready;
  logic [1:0]  d2_count, d3_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] q2[$];
  logic [31:0] q3[$];

  mesh_link #(.WIDTH(32), .DEPTH(2)) dut2 (
    .clk(clk), .nrst(nrst),
    .send_data(s2_data), .send_ready(s2_ready), .send_done(d2_done),
    .recv_data(d2_data), .recv_valid(d2_valid), .recv_ready(r2_ready),
    .count(d2_count)
  );

  mesh_link #(.WIDTH(32), .DEPTH(3)) dut3 (
    .clk(clk), .nrst(nrst),
    .send_data(s3_data), .send_ready(s3_ready), .send_done(d3_done),
    .recv_data(d3_data), .recv_valid(d3_valid), .recv_ready(r3_ready),
    .count(d3_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pop everything from d2 with recv_ready high, comparing against the scoreboard.
  task automatic drain2(input string nm);
    int guard;
    logic [31:0] exp;
    guard = 0;
    r2_ready = 1'b1;
    while (d2_valid === 1'b1 && guard < 20) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL %s_extra: got word %h expected none", nm, d2_data);
      end else begin
        exp = q2.pop_front();
        if (d2_data !== exp) begin
          errors++;
          $display("FAIL %s_order: got %h expected %h", nm, d2_data, exp);
        end
      end
      tick();
      guard++;
    end
    r2_ready = 1'b0;
    checks++;
    if (q2.size() != 0) begin
      errors++;
      $display("FAIL %s_lost: got %0d words left in scoreboard expected 0", nm, q2.size());
    end
    chk({nm, "_count"}, 32'(d2_count), 32'd0);
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    s2_ready = 1'b0; s3_ready = 1'b0; r2_ready = 1'b0; r3_ready = 1'b0;
    s2_data = '0; s3_data = '0;
    tick(); tick();
    chk("rst_done", 32'(d2_done), 32'd0);
    chk("rst_valid", 32'(d2_valid), 32'd0);
    chk("rst_count", 32'(d2_count), 32'd0);
    chk("rst_count3", 32'(d3_count), 32'd0);
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_single;
    s2_data = 32'hDEADBEEF; s2_ready = 1'b1; q2.push_back(32'hDEADBEEF);
    tick();
    chk("single_done", 32'(d2_done), 32'd1);
    chk("single_valid", 32'(d2_valid), 32'd1);
    chk("single_data", d2_data, 32'hDEADBEEF);
    chk("single_count", 32'(d2_count), 32'd1);
    s2_ready = 1'b0;
    tick();
    chk("single_pulse_end", 32'(d2_done), 32'd0);
    chk("single_hold", d2_data, 32'hDEADBEEF);
    drain2("single");
    chk("single_valid_after", 32'(d2_valid), 32'd0);
  endtask

  task automatic test_fill_and_pop_full;
    int pulses;
    pulses = 0;
    s2_data = 32'h1; s2_ready = 1'b1; q2.push_back(32'h1);
    tick();
    if (d2_done) pulses++;
    s2_data = 32'h2; q2.push_back(32'h2);
    tick();
    if (d2_done) pulses++;
    tick();
    if (d2_done) pulses++;
    s2_data = 32'h3; q2.push_back(32'h3);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (d2_done) pulses++;
    end
    chk("fill_pulses", 32'(pulses), 32'd2);
    chk("fill_count", 32'(d2_count), 32'd2);
    chk("fill_done_low", 32'(d2_done), 32'd0);
    chk("fill_head", d2_data, 32'h1);
    // Pop at full: the push of 0x3 must be refused on this edge.
    r2_ready = 1'b1;
    chk("popfull_word", d2_data, q2.pop_front());
    tick();
    r2_ready = 1'b0;
    chk("popfull_no_cap", 32'(d2_done), 32'd0);
    chk("popfull_count", 32'(d2_count), 32'd1);
    chk("popfull_head", d2_data, 32'h2);
    tick();
    chk("popfull_cap_next", 32'(d2_done), 32'd1);
    chk("popfull_count2", 32'(d2_count), 32'd2);
    s2_ready = 1'b0;
    tick();
    drain2("popfull");
  endtask

  task automatic test_wrap;
    int idx, got, cyc;
    logic [31:0] exp;
    idx = 0; got = 0; cyc = 0;
    s3_data = 32'h0; s3_ready = 1'b1; q3.push_back(32'h0);
    r3_ready = 1'b0;
    while ((idx < 10 || d3_valid === 1'b1) && cyc < 200) begin
      if (d3_valid === 1'b1 && r3_ready) begin
        checks++;
        if (q3.size() == 0) begin
          errors++;
          $display("FAIL wrap_extra: got word %h expected none", d3_data);
        end else begin
          exp = q3.pop_front();
          if (d3_data !== exp) begin
            errors++;
            $display("FAIL wrap_order: got %h expected %h", d3_data, exp);
          end
        end
        got++;
      end
      tick();
      cyc++;
      if (d3_count > 2'd3 || d3_count === 2'bxx) begin
        checks++; errors++;
        $display("FAIL wrap_count_range: got %0d expected 0..3", d3_count);
      end
      if (d3_done === 1'b1 && idx < 10) begin
        idx++;
        if (idx < 10) begin
          s3_data = 32'(idx);
          q3.push_back(32'(idx));
        end else begin
          s3_ready = 1'b0;
        end
      end
      r3_ready = ~r3_ready;
    end
    r3_ready = 1'b0;
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL wrap_timeout: got %0d cycles expected under 200", cyc);
    end
    chk("wrap_received", 32'(got), 32'd10);
    chk("wrap_left", 32'(q3.size()), 32'd0);
  endtask

  task automatic test_no_double;
    logic exp_done [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int   exp_cnt  [6] = '{1, 1, 2, 2, 2, 2};
    s2_data = 32'hAA; s2_ready = 1'b1;
    q2.push_back(32'hAA); q2.push_back(32'hAA);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("nodbl_done%0d", i), 32'(d2_done), 32'(exp_done[i]));
      chk($sformatf("nodbl_count%0d", i), 32'(d2_count), 32'(exp_cnt[i]));
    end
    s2_ready = 1'b0;
    drain2("nodbl");
  endtask

  task automatic test_reset_mid;
    s2_data = 32'h77; s2_ready = 1'b1;
    tick();
    chk("rmid_in_ack", 32'(d2_done), 32'd1);
    chk("rmid_pre_count", 32'(d2_count), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("rmid_done", 32'(d2_done), 32'd0);
    chk("rmid_valid", 32'(d2_valid), 32'd0);
    chk("rmid_count", 32'(d2_count), 32'd0);
    s2_data = 32'h55;
    tick();
    chk("rmid_hold_count", 32'(d2_count), 32'd0);
    nrst = 1'b1;
    q2.push_back(32'h55);
    tick();
    chk("rmid_recap_done", 32'(d2_done), 32'd1);
    chk("rmid_recap_count", 32'(d2_count), 32'd1);
    s2_ready = 1'b0;
    tick();
    drain2("rmid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_and_pop_full();
    test_wrap();
    test_no_double();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mesh_link.md
# mesh_link

Point-to-point mesh link buffer that joins one tile's outgoing port to a neighbouring tile's incoming port. It accepts words from the sender-side handshake (`send_ready`/`send_data` in, `send_done` out) into a small FIFO. It presents them on the receiver-side handshake (`recv_valid`/`recv_data` out, `recv_ready` in). The mesh fabric instantiates one `mesh_link` per direction between each pair of adjacent tiles.

## Interface

**Parameters**
- `WIDTH`, default 32: word width; matches `word`.
- `DEPTH`, default 2: FIFO entries; legal range is DEPTH ≥ 1. DEPTH need not be a power of two.

**Ports**
- `clk`, input, 1: clock, rising edge.
- `nrst`, input, 1: reset, asynchronous, active-low.
- `send_data`, input, WIDTH: word from the sending tile.
- `send_ready`, input, 1: the sending tile is offering `send_data`.
- `send_done`, output, 1: one-cycle pulse acknowledging capture of the offered word.
- `recv_data`, output, WIDTH: word at the FIFO head, driven to the receiving tile.
- `recv_valid`, output, 1: `recv_data` is valid.
- `recv_ready`, input, 1: the receiving tile accepts `recv_data` this cycle.
- `count`, output, $clog2(DEPTH+1): current FIFO occupancy.

## Operation

**Storage**
- DEPTH×WIDTH register array with read pointer `rd_ptr`, write pointer `wr_ptr` and occupancy `count`.
- Each pointer wraps from DEPTH-1 to 0.
- `full` = (count == DEPTH); `empty` = (count == 0).

**Input FSM, states IDLE and ACK**
- IDLE: the link captures a word when `send_ready`=1 and not `full`. On that edge it writes `send_data` to `mem[wr_ptr]`, increments `wr_ptr` and goes to ACK.
- IDLE: if `send_ready`=1 and `full`, the FSM stays in IDLE, captures nothing and holds `send_done`=0. The sender keeps holding its word.
- ACK: `send_done`=1. No capture occurs in this state, even though `send_ready` is still high; this prevents double capture, because the sender drops or changes `send_ready` only after it sees `send_done`. The next edge returns the FSM to IDLE unconditionally.
- `send_done` is a registered output equal to (state == ACK).

**Output side**
- `recv_valid` = !empty.
- `recv_data` = `mem[rd_ptr]`, driven combinationally from registered storage.
- A pop occurs on an edge where `recv_valid`=1 and `recv_ready`=1; `rd_ptr` increments on a pop.
- While `recv_valid`=1 and `recv_ready`=0, `recv_data` holds stable.
- `recv_ready` while empty has no effect.

**Occupancy**
- `count` increases by 1 on a push only, decreases by 1 on a pop only, and is unchanged on simultaneous push and pop.
- Push eligibility is evaluated on the pre-edge `full`. There is no same-cycle bypass: when the FIFO is full and a pop occurs, the push is still refused that edge.
- A pop requires a pre-edge non-empty FIFO. A word pushed at edge N cannot be popped at edge N.

**Ordering**
- Strict FIFO. No word is ever lost, duplicated or reordered.

## Timing

**Reset values** (while `nrst`=0, applied asynchronously):
- FSM in IDLE.
- `send_done`=0, `recv_valid`=0, `count`=0.
- `rd_ptr`=`wr_ptr`=0.
- `recv_data` is don't-care; storage is not cleared.

**Latency**
- The link captures at edge N.
- `send_done`=1 and `recv_valid`=1 are both visible in the cycle after edge N.
- The earliest pop of that word is at edge N+1.

**Throughput**
- Input side: at most 1 word per 2 cycles, because of the IDLE→ACK→IDLE cycle.
- Output side: 1 word per cycle.

**Handshake obligations**
- `send_done` is never high for two consecutive cycles.
- `send_done` is high only in the cycle immediately following a capture.

**Reset mid-operation**
- An assertion during ACK drops `send_done` immediately and discards the in-flight word; the sender must re-offer it.
- The first capture after `nrst` deasserts can happen no earlier than the first rising edge with `nrst`=1.

## Test plan

- **Single word:** after reset, drive `send_ready`=1 with `send_data`=0xDEADBEEF and `recv_ready`=0.
  - Required: `send_done` pulses exactly 1 cycle, then `recv_valid`=1, `recv_data`=0xDEADBEEF, `count`=1.
  - Then raise `recv_ready` for 1 cycle. Required: `recv_valid`=0, `count`=0.
- **Fill and backpressure:** DEPTH=2, `recv_ready`=0, offer 0x1, 0x2, 0x3.
  - Required: 2 `send_done` pulses, then `count`=2 and `send_done` held at 0 while 0x3 stays offered.
  - `recv_data` stays 0x1.
- **Pop at full:** from the full state above, assert `recv_ready` for 1 cycle.
  - Required: 0x1 is popped, 0x3 is not captured on that edge, and 0x3 is captured on the next edge.
  - Final `recv_valid` order: 0x2, 0x3.
- **Wrap-around:** DEPTH=3, stream 10 words 0x0–0x9 with `recv_ready` toggling every cycle.
  - Required: 0x0–0x9 arrive in order with no loss or duplication.
  - `count` is never above 3 and never below 0.
- **No double capture:** hold `send_ready`=1 with a constant 0xAA for 6 cycles, `recv_ready`=0.
  - Required: `send_done` pulses on alternate cycles only.
  - `count` increments once per pulse until full (2 for DEPTH=2).
- **Reset mid-operation:** assert `nrst`=0 asynchronously during ACK with `count`=1.
  - Required: `send_done`, `recv_valid` and `count` go to 0 immediately.
  - After release, a new word 0x55 is captured normally.
